// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller: time-multiplexed driver for an 8-digit, common-anode
// seven-segment display. Shadow registers hold the displayed digits, decimal
// points and scan mask; new values are adopted only while idle or at a frame
// boundary so a frame never mixes old and new content.
// Optional feature: define SSD_GHOST_BLANK_EN to insert BLANK_CYCLES of
// all-off dead time after every lit slot (suppresses ghosting).
module ssd_scan_controller #(
    parameter int TICK_DIV     = 262144,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [7:0]  An,
    output logic [7:0]  Cath
);

    localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int PW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

`ifdef SSD_GHOST_BLANK_EN
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHOW} state_t;
`endif

    state_t        state;
    logic [31:0]   sh_digits;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_mask;
    logic          pending;
    logic [PW-1:0] presc;
    logic [2:0]    idx;

    // Lowest set bit of a scan mask (0 when the mask is empty).
    function automatic logic [2:0] lowest_en(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Next enabled index above cur, wrapping 7 -> 0; cur itself if it is the only one.
    function automatic logic [2:0] next_en(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] j;
        r = cur;
        for (int k = 7; k >= 1; k--) begin
            j = cur + 3'(k);
            if (m[j]) r = j;
        end
        return r;
    endfunction

    // Active-low abcdefg pattern for one hex code.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    function automatic logic [7:0] an_of(input logic [2:0] i);
        return ~(8'b1 << i);
    endfunction

    function automatic logic [7:0] cath_of(input logic [31:0] d, input logic [7:0] p,
                                           input logic [2:0] i);
        return {seg7(d[4*i +: 4]), ~p[i]};
    endfunction

    logic [2:0] adv_idx;
    logic [2:0] low_idx;
    logic [2:0] new_low;
    logic       at_boundary;
    logic       slot_done;
    logic       take_new;

    assign adv_idx     = next_en(sh_mask, idx);
    assign low_idx     = lowest_en(sh_mask);
    assign new_low     = lowest_en(digit_en);
    assign at_boundary = (adv_idx == low_idx);

`ifdef SSD_GHOST_BLANK_EN
    logic show_done;
    assign show_done = (state == SHOW)  && (presc == PW'(TICK_DIV - 1));
    assign slot_done = (state == BLANK) && (presc == PW'(BLANK_CYCLES - 1));
`else
    assign slot_done = (state == SHOW)  && (presc == PW'(TICK_DIV - 1));
`endif

    // Shadows are refreshed while idle or when a slot ends on a frame boundary.
    assign take_new = pending && ((state == IDLE) || (slot_done && at_boundary));

    // Scan FSM, shadow registers, pending flag and registered display outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            state       <= IDLE;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_mask     <= '0;
            pending     <= 1'b0;
            presc       <= '0;
            idx         <= '0;
            An          <= 8'hFF;
            Cath        <= 8'hFF;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            pending     <= load | (pending & ~take_new);

            if (take_new) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_mask   <= digit_en;
                load_ack  <= 1'b1;
            end

            if (state == IDLE) begin
                presc <= '0;
                if (!pending && (sh_mask != 8'h00)) begin
                    state       <= SHOW;
                    idx         <= low_idx;
                    An          <= an_of(low_idx);
                    Cath        <= cath_of(sh_digits, sh_dp, low_idx);
                    frame_start <= 1'b1;
                end
            end else if (slot_done) begin
                presc <= '0;
                if (!at_boundary) begin
                    state <= SHOW;
                    idx   <= adv_idx;
                    An    <= an_of(adv_idx);
                    Cath  <= cath_of(sh_digits, sh_dp, adv_idx);
                end else if (pending) begin
                    if (digit_en == 8'h00) begin
                        state <= IDLE;
                        An    <= 8'hFF;
                        Cath  <= 8'hFF;
                    end else begin
                        state       <= SHOW;
                        idx         <= new_low;
                        An          <= an_of(new_low);
                        Cath        <= cath_of(digits_in, dp_in, new_low);
                        frame_start <= 1'b1;
                    end
                end else begin
                    state       <= SHOW;
                    idx         <= low_idx;
                    An          <= an_of(low_idx);
                    Cath        <= cath_of(sh_digits, sh_dp, low_idx);
                    frame_start <= 1'b1;
                end
            end
`ifdef SSD_GHOST_BLANK_EN
            else if (show_done) begin
                state <= BLANK;
                presc <= '0;
                An    <= 8'hFF;
                Cath  <= 8'hFF;
            end
`endif
            else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule
